// File: rtl/sensor_timing_gen_if.sv
// Video output bundle of sensor_timing_gen: frame/line framing, pixel data and frame status.
// The sensor drives (master) and the frame-buffer front end or BFM observes (slave).
interface sensor_timing_gen_if #(
    parameter int DATA_WIDTH      = 16,
    parameter int FRAME_CNT_WIDTH = 16
);
    // Handshake: push-only stream with no ready/backpressure. A pixel is transferred on
    // every clock where o_lval=1 (o_lval is only ever high while o_fval=1), and the
    // consumer must accept it on that clock.
    logic                       o_fval;
    logic                       o_lval;
    logic [DATA_WIDTH-1:0]      ov_pix_data;
    logic [FRAME_CNT_WIDTH-1:0] ov_frame_cnt;
    logic                       o_frame_done;

    modport master (
        output o_fval,
        output o_lval,
        output ov_pix_data,
        output ov_frame_cnt,
        output o_frame_done
    );

    modport slave (
        input o_fval,
        input o_lval,
        input ov_pix_data,
        input ov_frame_cnt,
        input o_frame_done
    );
endinterface

// File: rtl/sensor_timing_gen.sv
// Sensor-side fval/lval/pixel source for the frame-buffer pipeline; stops only on frame boundaries.
// Optional macro TEST_PATTERN_INC_EN: frame-wide incrementing pixel pattern instead of line+col.
module sensor_timing_gen #(
    parameter int DATA_WIDTH      = 16,
    parameter int SIZE_WIDTH      = 16,
    parameter int FVAL_LVAL_GAP   = 4,
    parameter int FRAME_CNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_acquisition_start,
    input  logic [SIZE_WIDTH-1:0] iv_width,
    input  logic [SIZE_WIDTH-1:0] iv_height,
    input  logic [SIZE_WIDTH-1:0] iv_h_blank,
    input  logic [SIZE_WIDTH-1:0] iv_v_blank,
    sensor_timing_gen_if.master   vid,
    output logic [2:0]            dbg_state
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FV_HEAD = 3'd1,
        S_LINE    = 3'd2,
        S_HBLANK  = 3'd3,
        S_FV_TAIL = 3'd4,
        S_VBLANK  = 3'd5
    } state_t;

    localparam logic [SIZE_WIDTH-1:0] ONE      = SIZE_WIDTH'(1);
    localparam logic [SIZE_WIDTH-1:0] GAP_LAST = SIZE_WIDTH'(FVAL_LVAL_GAP - 1);

    state_t                     state;
    logic [SIZE_WIDTH-1:0]      width_s, height_s, hblank_s, vblank_s;
    logic [SIZE_WIDTH-1:0]      cnt, col_idx, line_idx;
    logic                       fval, lval, frame_done;
    logic [DATA_WIDTH-1:0]      pix;
    logic [FRAME_CNT_WIDTH-1:0] frame_cnt;

    logic                       last_col, last_line;
    logic [SIZE_WIDTH-1:0]      vblank_last;

    assign last_col    = (col_idx == width_s - ONE);
    assign last_line   = (line_idx == height_s - ONE);
    // A zero vertical blank still spends one clock in VBLANK.
    assign vblank_last = (vblank_s == '0) ? '0 : vblank_s - ONE;

`ifdef TEST_PATTERN_INC_EN
    logic [DATA_WIDTH-1:0] inc_val;
`else
    function automatic logic [DATA_WIDTH-1:0] pix_sum(input logic [SIZE_WIDTH-1:0] l,
                                                      input logic [SIZE_WIDTH-1:0] c);
        return DATA_WIDTH'(l) + DATA_WIDTH'(c);
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            width_s    <= '0;
            height_s   <= '0;
            hblank_s   <= '0;
            vblank_s   <= '0;
            cnt        <= '0;
            col_idx    <= '0;
            line_idx   <= '0;
            fval       <= 1'b0;
            lval       <= 1'b0;
            frame_done <= 1'b0;
            pix        <= '0;
            frame_cnt  <= '0;
`ifdef TEST_PATTERN_INC_EN
            inc_val    <= '0;
`endif
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Sizes are captured here only, so mid-frame edits wait for the next frame.
                    if (i_acquisition_start && iv_width != '0 && iv_height != '0) begin
                        width_s  <= iv_width;
                        height_s <= iv_height;
                        hblank_s <= iv_h_blank;
                        vblank_s <= iv_v_blank;
                        cnt      <= '0;
                        fval     <= 1'b1;
                        state    <= S_FV_HEAD;
                    end
                end

                S_FV_HEAD: begin
                    if (cnt == GAP_LAST) begin
                        state    <= S_LINE;
                        lval     <= 1'b1;
                        line_idx <= '0;
                        col_idx  <= '0;
                        cnt      <= '0;
`ifdef TEST_PATTERN_INC_EN
                        pix      <= DATA_WIDTH'(frame_cnt);
                        inc_val  <= DATA_WIDTH'(frame_cnt) + DATA_WIDTH'(1);
`else
                        pix      <= '0;
`endif
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end

                S_LINE: begin
                    if (!last_col) begin
                        col_idx <= col_idx + ONE;
`ifdef TEST_PATTERN_INC_EN
                        pix     <= inc_val;
                        inc_val <= inc_val + DATA_WIDTH'(1);
`else
                        pix     <= pix_sum(line_idx, col_idx + ONE);
`endif
                    end else if (last_line) begin
                        state <= S_FV_TAIL;
                        lval  <= 1'b0;
                        pix   <= '0;
                        cnt   <= '0;
                    end else if (hblank_s == '0) begin
                        // No horizontal blank: next line follows with lval held high.
                        line_idx <= line_idx + ONE;
                        col_idx  <= '0;
`ifdef TEST_PATTERN_INC_EN
                        pix      <= inc_val;
                        inc_val  <= inc_val + DATA_WIDTH'(1);
`else
                        pix      <= pix_sum(line_idx + ONE, '0);
`endif
                    end else begin
                        state <= S_HBLANK;
                        lval  <= 1'b0;
                        pix   <= '0;
                        cnt   <= '0;
                    end
                end

                S_HBLANK: begin
                    if (cnt == hblank_s - ONE) begin
                        state    <= S_LINE;
                        lval     <= 1'b1;
                        line_idx <= line_idx + ONE;
                        col_idx  <= '0;
                        cnt      <= '0;
`ifdef TEST_PATTERN_INC_EN
                        pix      <= inc_val;
                        inc_val  <= inc_val + DATA_WIDTH'(1);
`else
                        pix      <= pix_sum(line_idx + ONE, '0);
`endif
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end

                S_FV_TAIL: begin
                    if (cnt == GAP_LAST) begin
                        state      <= S_VBLANK;
                        fval       <= 1'b0;
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + FRAME_CNT_WIDTH'(1);
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end

                S_VBLANK: begin
                    if (cnt == vblank_last) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    fval  <= 1'b0;
                    lval  <= 1'b0;
                    pix   <= '0;
                end
            endcase
        end
    end

    assign vid.o_fval       = fval;
    assign vid.o_lval       = lval;
    assign vid.ov_pix_data  = pix;
    assign vid.ov_frame_cnt = frame_cnt;
    assign vid.o_frame_done = frame_done;
    assign dbg_state        = state;
endmodule

// File: doc/sensor_timing_gen.md
Name: sensor_timing_gen

Overview:
Synthesizable sensor-side source for the frame-buffer pipeline. Generates the i_fval/i_lval framing and pixel data that the frame-buffer front end and the frame-buffer BFM consume. Lets the frame buffer be exercised on hardware and in simulation without the MT9P031 model. Start/stop respects frame integrity: a stop request never truncates a frame that is already in progress.

Parameters:
DATA_WIDTH, 16, pixel data width in bits
SIZE_WIDTH, 16, width of all size and blanking registers
FVAL_LVAL_GAP, 4, clocks from o_fval rising to the first o_lval rising, and from the last o_lval falling to o_fval falling (must be ≥1)
FRAME_CNT_WIDTH, 16, width of the frame counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
i_acquisition_start  in  1  level; 1 = run continuously, 0 = stop after the current frame
iv_width  in  SIZE_WIDTH  active pixels per line
iv_height  in  SIZE_WIDTH  active lines per frame
iv_h_blank  in  SIZE_WIDTH  clocks between lines (lval low inside fval)
iv_v_blank  in  SIZE_WIDTH  clocks with fval low between frames
o_fval  out  1  frame valid
o_lval  out  1  line valid
ov_pix_data  out  DATA_WIDTH  pixel data, valid only when o_lval=1
ov_frame_cnt  out  FRAME_CNT_WIDTH  count of completed frames
o_frame_done  out  1  one-clock pulse on the cycle o_fval falls

Behaviour:
- Reset values: o_fval=0, o_lval=0, ov_pix_data=0, ov_frame_cnt=0, o_frame_done=0. State=IDLE. All counters cleared.
- Reset has priority over every other event. Reset mid-frame drops o_fval and o_lval on the next edge, with no o_frame_done pulse.
- All outputs are registered. ov_pix_data is 0 whenever o_lval=0.
- Shadow registers: iv_width, iv_height, iv_h_blank and iv_v_blank are latched only on the IDLE→FV_HEAD transition. Changes mid-frame have no effect until the next frame.
- State machine:
  - IDLE: if i_acquisition_start=1 and width≠0 and height≠0 → FV_HEAD, and o_fval=1 on the next clock. With a zero size, stay in IDLE.
  - FV_HEAD: FVAL_LVAL_GAP clocks with fval=1, lval=0 → LINE.
  - LINE: lval=1 for exactly width clocks; column counter runs 0..width-1.
    - If this is the last line → FV_TAIL.
    - Else if h_blank=0 → LINE again, lval stays high continuously.
    - Else → HBLANK.
  - HBLANK: h_blank clocks with lval=0 → LINE; line counter increments.
  - FV_TAIL: FVAL_LVAL_GAP clocks with fval=1, lval=0, then fval falls. On that cycle o_frame_done=1 and ov_frame_cnt increments (wraps modulo 2^FRAME_CNT_WIDTH) → VBLANK.
  - VBLANK: v_blank clocks with fval=0 (v_blank=0 means 1 clock minimum) → IDLE. IDLE re-evaluates i_acquisition_start on the same cycle, so in continuous mode the fval-low gap is max(v_blank,1)+1 clocks.
- i_acquisition_start is sampled only in IDLE. Deasserting it during FV_HEAD, LINE, HBLANK or FV_TAIL completes the full frame.
- Default data pattern: ov_pix_data = (line_idx + col_idx) mod 2^DATA_WIDTH, where line_idx and col_idx are 0-based.
- Frame length in clocks with fval high = 2·FVAL_LVAL_GAP + height·width + (height-1)·h_blank.

Optional Feature:
Macro TEST_PATTERN_INC_EN.
- Defined: ov_pix_data is a frame-wide incrementing counter. It starts at the low DATA_WIDTH bits of ov_frame_cnt on the first pixel of each frame, increments once per valid pixel, and wraps modulo 2^DATA_WIDTH. This lets the checker detect dropped, duplicated or reordered pixels across frames.
- Undefined: the default (line_idx + col_idx) pattern is used, and the counter logic is not synthesized.

Test Plan:
- Single frame: reset, then width=4, height=3, h_blank=2, v_blank=5, start=1 for one frame then 0. Expect:
  - o_fval high for exactly 2·4+12+4=24 clocks;
  - 3 lval pulses of 4 clocks each, separated by 2-clock gaps;
  - line 1 data = 1,2,3,4;
  - o_frame_done pulses once; ov_frame_cnt=1; the block returns to IDLE and stays there.
- Stop mid-frame: start=1, then drop start during line 2 of 8 lines. Expect all 8 lines output, fval falls normally, and no second frame.
- Back-to-back frames: h_blank=0, v_blank=0, width=2, height=2, start held at 1. Expect lval high 4 clocks continuously, fval low exactly 2 clocks between frames, and ov_frame_cnt incrementing 1,2,3.
- Mid-frame config change: change iv_width from 4 to 8 during frame 1. Expect frame 1 lines of 4 pixels and frame 2 lines of 8 pixels.
- Zero size and reset:
  - width=0 with start=1 → o_fval stays 0 indefinitely.
  - Assert reset during LINE → next clock o_fval=0, o_lval=0, ov_frame_cnt=0, with no frame_done pulse.
- With TEST_PATTERN_INC_EN defined: width=3, height=2, 2 frames. Expect frame 0 data 0..5 and frame 1 data 1..6.
